// File: rtl/ifmap_spad_ctrl.sv
// Ifmap scratch-pad sequencer: fills an S-word sliding window, then issues S tap reads per output position.
// Taps are zero-latency (address and data in the same cycle). Stalls on in_valid=0 or tap_ready=0.
// Build option IFMAP_SPAD_PREFETCH_EN writes the next window word during COMPUTE, so SHIFT is skipped.
module ifmap_spad_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_REGS      = 16,
  parameter int ADDR_WIDTH    = $clog2(NUM_REGS),
  parameter int OUT_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_WIDTH:0]      cfg_kernel_size,
  input  logic [OUT_CNT_WIDTH-1:0] cfg_num_outputs,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     spad_write_en,
  output logic [ADDR_WIDTH-1:0]    spad_write_addr,
  output logic [DATA_WIDTH-1:0]    spad_write_data,
  output logic [ADDR_WIDTH-1:0]    spad_read_addr,
  output logic                     tap_valid,
  output logic                     tap_last,
  input  logic                     tap_ready,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {IDLE, FILL, COMPUTE, SHIFT, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = NUM_REGS[ADDR_WIDTH:0];

  state_t                   state, state_nxt;
  logic [ADDR_WIDTH:0]      s_reg, fill_cnt, s_m1;
  logic [OUT_CNT_WIDTH-1:0] n_reg, out_cnt, out_inc;
  logic [ADDR_WIDTH-1:0]    wr_ptr, head, tap_idx;
  logic                     cfg_bad, last_tap, tap_fire;
`ifdef IFMAP_SPAD_PREFETCH_EN
  logic                     pf;
`endif

  assign s_m1     = s_reg - 1'b1;
  assign out_inc  = out_cnt + 1'b1;
  assign last_tap = (tap_idx == s_m1[ADDR_WIDTH-1:0]);
  assign tap_fire = tap_valid & tap_ready;
  assign cfg_bad  = (cfg_kernel_size == '0) || (cfg_kernel_size > NUM_REGS_W) ||
                    (cfg_num_outputs == '0);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    tap_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = cfg_bad ? DONE : FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && (fill_cnt == s_m1)) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        tap_valid = 1'b1;
`ifdef IFMAP_SPAD_PREFETCH_EN
        // Slot head+S lies outside the active window only while S < NUM_REGS.
        in_ready = !pf && (out_inc < n_reg) && (s_reg < NUM_REGS_W);
`endif
        if (tap_fire && last_tap) begin
          if (out_inc == n_reg) begin
            state_nxt = DONE;
          end else begin
`ifdef IFMAP_SPAD_PREFETCH_EN
            state_nxt = (pf || (in_valid && in_ready)) ? COMPUTE : SHIFT;
`else
            state_nxt = SHIFT;
`endif
          end
        end
      end
      SHIFT: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = COMPUTE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign spad_write_en   = in_valid & in_ready;
  assign spad_write_addr = wr_ptr;
  assign spad_write_data = in_ready ? in_data : '0;
  assign spad_read_addr  = tap_valid ? (head + tap_idx) : '0;
  assign tap_last        = tap_valid & last_tap;
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s_reg    <= '0;
      n_reg    <= '0;
      fill_cnt <= '0;
      wr_ptr   <= '0;
      head     <= '0;
      tap_idx  <= '0;
      out_cnt  <= '0;
`ifdef IFMAP_SPAD_PREFETCH_EN
      pf       <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        s_reg    <= cfg_kernel_size;
        n_reg    <= cfg_num_outputs;
        fill_cnt <= '0;
        wr_ptr   <= '0;
        head     <= '0;
        tap_idx  <= '0;
        out_cnt  <= '0;
`ifdef IFMAP_SPAD_PREFETCH_EN
        pf       <= 1'b0;
`endif
      end
      if (spad_write_en) wr_ptr <= wr_ptr + 1'b1;
      if (state == FILL && spad_write_en) fill_cnt <= fill_cnt + 1'b1;
      if (tap_fire) begin
        if (last_tap) begin
          tap_idx <= '0;
          head    <= head + 1'b1;
          out_cnt <= out_inc;
        end else begin
          tap_idx <= tap_idx + 1'b1;
        end
      end
`ifdef IFMAP_SPAD_PREFETCH_EN
      // A prefetch landing on the last tap is consumed immediately by the next window.
      if (tap_fire && last_tap)                   pf <= 1'b0;
      else if (state == COMPUTE && spad_write_en) pf <= 1'b1;
`endif
    end
  end

endmodule
